issue_ctrl: RTL

ISSUE_CTRL -- requirements
Module: issue_ctrl

---
 rtl/issue_ctrl_pkg.sv | 15 +
 rtl/issue_scoreboard.sv | 53 +++++
 rtl/issue_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/issue_ctrl_pkg.sv
// Shared widths and constants for the issue stage.
// Every block that needs the default widths or the link register imports this package.
package issue_ctrl_pkg;

    localparam int DWIDTH_DEF = 32;
    localparam int AWIDTH_DEF = 5;
    localparam int PC_WIDTH_DEF = 32;
    localparam int IMM_WIDTH_DEF = 16;
    localparam int FUNCT_WIDTH_DEF = 6;
    localparam int OPCODE_WIDTH_DEF = 6;
    localparam int JUMP_WIDTH_DEF = 26;
    localparam int LINK_REG = 31;
    localparam int STALL_WIDTH = 16;

endpackage

// File: rtl/issue_scoreboard.sv
// Register busy vector: set on issue, clear on writeback, wiped by flush.
// Lookups see a same-cycle writeback clear so retiring producers stop stalling.
module issue_scoreboard
    import issue_ctrl_pkg::*;
#(
    parameter int AWIDTH = AWIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       set_en_i,
    input  logic [AWIDTH-1:0]          set_addr_i,
    input  logic                       clr_en_i,
    input  logic [AWIDTH-1:0]          clr_addr_i,
    input  logic [AWIDTH-1:0]          rs_addr_i,
    input  logic [AWIDTH-1:0]          rt_addr_i,
    input  logic [AWIDTH-1:0]          dst_addr_i,
    output logic                       rs_busy_o,
    output logic                       rt_busy_o,
    output logic                       dst_busy_o,
    output logic [(1<<AWIDTH)-1:0]     busy_o
);

    localparam int NREG = 1 << AWIDTH;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;
    logic [NREG-1:0] busy_eff;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en_i) set_mask[set_addr_i] = 1'b1;
        if (clr_en_i) clr_mask[clr_addr_i] = 1'b1;
        busy_eff = busy_q & ~clr_mask;
        busy_d = flush_i ? '0 : (busy_eff | set_mask);
        // $0 is never a real producer
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign rs_busy_o  = busy_eff[rs_addr_i];
    assign rt_busy_o  = busy_eff[rt_addr_i];
    assign dst_busy_o = busy_eff[dst_addr_i];
    assign busy_o     = busy_q;

endmodule

// File: rtl/issue_ctrl.sv
// In-order issue stage: scoreboard hazard check, one registered slot to execute.
// Stalls on RAW/WAW against in-flight writers; counts stall cycles.
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int DWIDTH       = DWIDTH_DEF,
    parameter int AWIDTH       = AWIDTH_DEF,
    parameter int PC_WIDTH     = PC_WIDTH_DEF,
    parameter int IMM_WIDTH    = IMM_WIDTH_DEF,
    parameter int FUNCT_WIDTH  = FUNCT_WIDTH_DEF,
    parameter int OPCODE_WIDTH = OPCODE_WIDTH_DEF,
    parameter int JUMP_WIDTH   = JUMP_WIDTH_DEF
) (
    input  logic                    ic_clk,
    input  logic                    ic_rst,
    input  logic                    ic_i_empty,
    output logic                    ic_o_re,
    input  logic [PC_WIDTH-1:0]     ic_i_pc,
    input  logic [IMM_WIDTH-1:0]    ic_i_imm,
    input  logic [FUNCT_WIDTH-1:0]  ic_i_funct,
    input  logic [OPCODE_WIDTH-1:0] ic_i_opcode,
    input  logic [JUMP_WIDTH-1:0]   ic_i_jal_addr,
    input  logic [DWIDTH-1:0]       ic_i_data_rs,
    input  logic [DWIDTH-1:0]       ic_i_data_rt,
    input  logic [AWIDTH-1:0]       ic_i_addr_rs,
    input  logic [AWIDTH-1:0]       ic_i_addr_rt,
    input  logic [AWIDTH-1:0]       ic_i_addr_rd,
    input  logic                    ic_i_reg_dst,
    input  logic                    ic_i_alu_src,
    input  logic                    ic_i_regwrite,
    input  logic                    ic_i_memtoreg,
    input  logic                    ic_i_memwrite,
    input  logic                    ic_i_jr,
    input  logic                    ic_i_jal,
    output logic [PC_WIDTH-1:0]     ic_o_pc,
    output logic [IMM_WIDTH-1:0]    ic_o_imm,
    output logic [FUNCT_WIDTH-1:0]  ic_o_funct,
    output logic [OPCODE_WIDTH-1:0] ic_o_opcode,
    output logic [JUMP_WIDTH-1:0]   ic_o_jal_addr,
    output logic [DWIDTH-1:0]       ic_o_data_rs,
    output logic [DWIDTH-1:0]       ic_o_data_rt,
    output logic [AWIDTH-1:0]       ic_o_addr_rs,
    output logic [AWIDTH-1:0]       ic_o_addr_rt,
    output logic [AWIDTH-1:0]       ic_o_addr_rd,
    output logic [AWIDTH-1:0]       ic_o_addr_dst,
    output logic                    ic_o_reg_dst,
    output logic                    ic_o_alu_src,
    output logic                    ic_o_regwrite,
    output logic                    ic_o_memtoreg,
    output logic                    ic_o_memwrite,
    output logic                    ic_o_jr,
    output logic                    ic_o_jal,
    output logic                    ic_o_valid,
    input  logic                    ic_i_ready,
    input  logic                    ic_i_wb_en,
    input  logic [AWIDTH-1:0]       ic_i_wb_addr,
    input  logic                    ic_i_flush,
    output logic [STALL_WIDTH-1:0]  ic_o_stall_cnt
);

    localparam int SLOT_W = PC_WIDTH + IMM_WIDTH + FUNCT_WIDTH + OPCODE_WIDTH
                          + JUMP_WIDTH + 2*DWIDTH + 4*AWIDTH + 7;

    logic [AWIDTH-1:0]      head_dst;
    logic                   head_writes;
    logic                   rs_read;
    logic                   rt_read;
    logic                   rs_busy;
    logic                   rt_busy;
    logic                   dst_busy;
    logic                   hazard;
    logic                   slot_free;
    logic                   issue;
    logic [SLOT_W-1:0]      head_bus;
    logic [SLOT_W-1:0]      slot_d;
    logic [SLOT_W-1:0]      slot_q;
    logic                   valid_d;
    logic                   valid_q;
    logic [STALL_WIDTH-1:0] stall_d;
    logic [STALL_WIDTH-1:0] stall_q;
    logic [(1<<AWIDTH)-1:0] busy_vec;

    always_comb begin
        if (ic_i_jal)          head_dst = AWIDTH'(LINK_REG);
        else if (ic_i_reg_dst) head_dst = ic_i_addr_rd;
        else                   head_dst = ic_i_addr_rt;
    end

    assign head_writes = ic_i_regwrite && (head_dst != '0);
    assign rs_read     = !ic_i_jal;
    assign rt_read     = ic_i_reg_dst || ic_i_memwrite;

    assign hazard = !ic_i_empty
                 && ((rs_read && rs_busy)
                  || (rt_read && rt_busy)
                  || (head_writes && dst_busy));

    assign slot_free = !valid_q || ic_i_ready;
    assign issue     = ic_rst && !ic_i_empty && !hazard
                    && slot_free && !ic_i_flush;
    assign ic_o_re   = issue;

    issue_scoreboard #(.AWIDTH(AWIDTH)) u_sb (
        .clk        (ic_clk),
        .rst_n      (ic_rst),
        .flush_i    (ic_i_flush),
        .set_en_i   (issue && head_writes),
        .set_addr_i (head_dst),
        .clr_en_i   (ic_i_wb_en),
        .clr_addr_i (ic_i_wb_addr),
        .rs_addr_i  (ic_i_addr_rs),
        .rt_addr_i  (ic_i_addr_rt),
        .dst_addr_i (head_dst),
        .rs_busy_o  (rs_busy),
        .rt_busy_o  (rt_busy),
        .dst_busy_o (dst_busy),
        .busy_o     (busy_vec)
    );

    assign head_bus = {ic_i_pc, ic_i_imm, ic_i_funct, ic_i_opcode,
                       ic_i_jal_addr, ic_i_data_rs, ic_i_data_rt,
                       ic_i_addr_rs, ic_i_addr_rt, ic_i_addr_rd, head_dst,
                       ic_i_reg_dst, ic_i_alu_src, ic_i_regwrite,
                       ic_i_memtoreg, ic_i_memwrite, ic_i_jr, ic_i_jal};

    always_comb begin
        slot_d  = slot_q;
        valid_d = valid_q;
        stall_d = stall_q;
        if (ic_i_flush) begin
            valid_d = 1'b0;
            stall_d = '0;
        end else begin
            if (issue) begin
                slot_d  = head_bus;
                valid_d = 1'b1;
            end else if (ic_i_ready) begin
                valid_d = 1'b0;
            end
            if (hazard && (stall_q != '1)) stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge ic_clk or negedge ic_rst) begin
        if (!ic_rst) begin
            slot_q  <= '0;
            valid_q <= 1'b0;
            stall_q <= '0;
        end else begin
            slot_q  <= slot_d;
            valid_q <= valid_d;
            stall_q <= stall_d;
        end
    end

    assign {ic_o_pc, ic_o_imm, ic_o_funct, ic_o_opcode,
            ic_o_jal_addr, ic_o_data_rs, ic_o_data_rt,
            ic_o_addr_rs, ic_o_addr_rt, ic_o_addr_rd, ic_o_addr_dst,
            ic_o_reg_dst, ic_o_alu_src, ic_o_regwrite,
            ic_o_memtoreg, ic_o_memwrite, ic_o_jr, ic_o_jal} = slot_q;

    assign ic_o_valid     = valid_q;
    assign ic_o_stall_cnt = stall_q;

endmodule
